// File: rtl/wb_ram_responder.sv
// wb_ram_responder
// Pipelined Wishbone B4 slave backed by a single-port word RAM.
// Byte-addressed 32-bit accesses with per-lane write enables. Every accepted
// request gets exactly one ack (in range) or err (out of range) after a fixed
// LATENCY cycles, in order. Optional stall injection throttles the master
// every STALL_EVERY accepted requests. Dropping wb_cyc_i discards every
// response still in flight.
//
// DW must be 32, LATENCY must lie in 1..8, and AW must be at least
// DEPTH_LOG2+2.

module wb_ram_responder #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int LATENCY     = 2,
    parameter int STALL_EVERY = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [AW-1:0] wb_addr_i,
    input  logic [3:0]    wb_sel_i,
    input  logic [DW-1:0] wb_wdata_i,
    output logic          wb_stall_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o,
    output logic [DW-1:0] wb_rdata_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // One response-pipeline stage. 'rd' marks an in-range read whose data is
    // still sitting in the RAM output register (only meaningful in stage 0).
    typedef struct packed {
        logic          valid;
        logic          err;
        logic          rd;
        logic [DW-1:0] data;
    } stage_t;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                  r_stall;
    logic                  w_accept;
    logic                  w_oor;
    logic                  w_wr_en;
    logic [DEPTH_LOG2-1:0] w_word_idx;
    logic                  w_unused_addr_lsb;

    assign w_accept   = wb_cyc_i & wb_stb_i & ~r_stall;
    assign w_word_idx = wb_addr_i[DEPTH_LOG2+1:2];

    // Byte offset within the word plays no part in addressing.
    assign w_unused_addr_lsb = ^wb_addr_i[1:0];

    generate
        if (AW > DEPTH_LOG2 + 2) begin : g_oor
            assign w_oor = |wb_addr_i[AW-1:DEPTH_LOG2+2];
        end else begin : g_no_oor
            assign w_oor = 1'b0;
        end
    endgenerate

    // Reset on the same edge wins over a write accepted on that edge.
    assign w_wr_en = w_accept & wb_we_i & ~w_oor & ~rst_i;

    // ------------------------------------------------------------------
    // Backing RAM
    // ------------------------------------------------------------------
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd_word;

    // Byte-lane writes and a registered read of the addressed word on accept.
    // NOTE: the RAM has no reset so it maps onto block RAM and its contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_rd_word <= r_mem[w_word_idx];
        end
        for (int k = 0; k < 4; k++) begin
            if (w_wr_en && wb_sel_i[k]) begin
                r_mem[w_word_idx][8*k +: 8] <= wb_wdata_i[8*k +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response pipeline
    // ------------------------------------------------------------------
    stage_t r_pipe     [LATENCY];
    stage_t w_pipe_nxt [LATENCY];
    stage_t w_head;
    stage_t w_final;

    // Stage 0 with its read data taken from the RAM output register.
    always_comb begin
        // NOTE: assign the whole struct first so no field can infer a latch.
        w_head      = r_pipe[0];
        w_head.data = r_pipe[0].rd ? r_rd_word : '0;
    end

    // Next state of every stage; an idle bus (cyc low) kills all valids.
    always_comb begin
        w_pipe_nxt[0].valid = w_accept;
        w_pipe_nxt[0].err   = w_accept & w_oor;
        w_pipe_nxt[0].rd    = w_accept & ~wb_we_i & ~w_oor;
        w_pipe_nxt[0].data  = '0;
        for (int i = 1; i < LATENCY; i++) begin
            w_pipe_nxt[i]       = (i == 1) ? w_head : r_pipe[i-1];
            w_pipe_nxt[i].valid = w_pipe_nxt[i].valid & wb_cyc_i;
        end
    end

    // Advance the response pipeline; reset drops everything in flight.
    // NOTE: state registers use non-blocking assignment so all stages shift on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                r_pipe[i] <= w_pipe_nxt[i];
            end
        end
    end

    assign w_final = (LATENCY == 1) ? w_head : r_pipe[LATENCY-1];

    // Responses are suppressed in the very cycle the master drops cyc.
    assign wb_ack_o   = w_final.valid & ~w_final.err & wb_cyc_i;
    assign wb_err_o   = w_final.valid &  w_final.err & wb_cyc_i;
    assign wb_rdata_o = wb_ack_o ? w_final.data : '0;
    assign wb_rty_o   = 1'b0;

    // ------------------------------------------------------------------
    // Stall injection
    // ------------------------------------------------------------------
    generate
        if (STALL_EVERY > 0) begin : g_stall
            localparam int CW = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;

            logic [CW-1:0] r_stall_cnt;

            // Count accepts; after every STALL_EVERY-th one, stall for one cycle.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_stall_cnt <= '0;
                    r_stall     <= 1'b0;
                end else begin
                    r_stall <= 1'b0;
                    if (w_accept) begin
                        if (r_stall_cnt == CW'(STALL_EVERY - 1)) begin
                            r_stall_cnt <= '0;
                            r_stall     <= 1'b1;
                        end else begin
                            r_stall_cnt <= r_stall_cnt + 1'b1;
                        end
                    end
                end
            end
        end else begin : g_no_stall
            assign r_stall = 1'b0;
        end
    endgenerate

    assign wb_stall_o = r_stall;

endmodule

// File: tb/tb_wb_ram_responder.sv
// tb_wb_ram_responder
// Directed scenarios plus randomized traffic, checked every cycle against a
// reference model that keeps a word array and a queue of timestamped
// expected responses.

module tb_wb_ram_responder;

    localparam int AW          = 32;
    localparam int DW          = 32;
    localparam int DEPTH_LOG2  = 10;
    localparam int LATENCY     = 3;
    localparam int STALL_EVERY = 4;
    localparam int DEPTH       = 1 << DEPTH_LOG2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic          wb_we_i;
    logic [AW-1:0] wb_addr_i;
    logic [3:0]    wb_sel_i;
    logic [DW-1:0] wb_wdata_i;
    logic          wb_stall_o;
    logic          wb_ack_o;
    logic          wb_err_o;
    logic          wb_rty_o;
    logic [DW-1:0] wb_rdata_o;

    always #5 clk = ~clk;

    wb_ram_responder #(
        .AW          (AW),
        .DW          (DW),
        .DEPTH_LOG2  (DEPTH_LOG2),
        .LATENCY     (LATENCY),
        .STALL_EVERY (STALL_EVERY)
    ) u_dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_addr_i  (wb_addr_i),
        .wb_sel_i   (wb_sel_i),
        .wb_wdata_i (wb_wdata_i),
        .wb_stall_o (wb_stall_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .wb_rty_o   (wb_rty_o),
        .wb_rdata_o (wb_rdata_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference model: word array plus in-order queue of responses, each
    // tagged with the cycle in which it must appear.
    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic [31:0] m_mem [DEPTH];
    resp_t       m_q [$];
    int          now;
    bit          m_stall;
    int          m_cnt;

    // Observations of the DUT used by the directed checks.
    int          n_ack;
    int          n_err;
    int          n_stall_seen;
    bit          last_acc;
    logic [31:0] last_data;
    int          acc_cyc [$];
    int          ack_cyc [$];
    logic [31:0] ack_data [$];

    // One bus cycle: drive, check against the model, clock, advance the model.
    task automatic step(input bit r, input bit c, input bit s, input bit w,
                        input logic [31:0] a, input logic [3:0] se, input logic [31:0] d);
        bit          e_v;
        bit          e_ack;
        bit          e_err;
        logic [31:0] e_data;
        bit          acc;
        bit          oor;
        int          idx;
        logic [31:0] rd;
        resp_t       nr;

        rst_i = r; wb_cyc_i = c; wb_stb_i = s; wb_we_i = w;
        wb_addr_i = a; wb_sel_i = se; wb_wdata_i = d;
        #1;
        e_v    = (m_q.size() > 0) && (m_q[0].due == now);
        e_ack  = e_v && !m_q[0].err && c;
        e_err  = e_v &&  m_q[0].err && c;
        e_data = e_ack ? m_q[0].data : 32'h0;
        check("stall", {31'b0, wb_stall_o}, {31'b0, m_stall});
        check("ack",   {31'b0, wb_ack_o},   {31'b0, e_ack});
        check("err",   {31'b0, wb_err_o},   {31'b0, e_err});
        check("rdata", wb_rdata_o, e_data);
        check("rty",   {31'b0, wb_rty_o},   32'h0);

        if (wb_ack_o === 1'b1) begin
            n_ack++;
            last_data = wb_rdata_o;
            ack_cyc.push_back(now);
            ack_data.push_back(wb_rdata_o);
        end
        if (wb_err_o === 1'b1) n_err++;
        if (wb_stall_o === 1'b1) n_stall_seen++;
        last_acc = c && s && (wb_stall_o === 1'b0);
        if (last_acc) acc_cyc.push_back(now);

        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_stall = 1'b0;
            m_cnt   = 0;
        end else begin
            acc = c && s && !m_stall;
            if (e_v) m_q.delete(0);
            if (!c) m_q.delete();
            if (acc) begin
                oor = (a >> (DEPTH_LOG2 + 2)) != 0;
                idx = int'((a >> 2) & (DEPTH - 1));
                rd  = m_mem[idx];
                if (w && !oor) begin
                    for (int k = 0; k < 4; k++) begin
                        if (se[k]) m_mem[idx][8*k +: 8] = d[8*k +: 8];
                    end
                end
                nr.due  = now + LATENCY;
                nr.err  = oor;
                nr.data = (!w && !oor) ? rd : 32'h0;
                m_q.push_back(nr);
                m_cnt++;
                if (m_cnt == STALL_EVERY) begin
                    m_cnt   = 0;
                    m_stall = 1'b1;
                end else begin
                    m_stall = 1'b0;
                end
            end else begin
                m_stall = 1'b0;
            end
        end
        now++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    // Hold the strobe until the request is accepted (bounded).
    task automatic req(input bit w, input logic [31:0] a, input logic [3:0] se, input logic [31:0] d);
        for (int t = 0; t < 8; t++) begin
            step(1'b0, 1'b1, 1'b1, w, a, se, d);
            if (last_acc) return;
        end
        check("req_timeout", 32'h0, 32'h1);
    endtask

    task automatic clear_obs();
        acc_cyc.delete();
        ack_cyc.delete();
        ack_data.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_ack;
        int base_err;
        int base_stall;
        bit r;
        bit c;
        bit s;
        bit w;
        logic [31:0] a;

        now = 0; m_stall = 1'b0; m_cnt = 0;
        n_ack = 0; n_err = 0; n_stall_seen = 0; last_acc = 1'b0; last_data = '0;
        rst_i = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_addr_i = '0; wb_sel_i = '0; wb_wdata_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state (outputs checked inside step).
        do_reset();
        check("reset_outs", {29'b0, wb_ack_o, wb_err_o, wb_stall_o}, 32'h0);
        check("reset_rdata", wb_rdata_o, 32'h0);

        // Preload the first 64 words with random data.
        for (int i = 0; i < 64; i++) req(1'b1, 32'(i * 4), 4'hF, $urandom);
        idle(LATENCY + 1);

        // Write then read on the next cycle.
        clear_obs();
        base_err = n_err;
        req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        req(1'b0, 32'h10, 4'hF, 32'h0);
        idle(LATENCY + 2);
        check("t1_resp_n", ack_cyc.size(), 2);
        check("t1_acc_n", acc_cyc.size(), 2);
        if (ack_cyc.size() == 2 && acc_cyc.size() == 2) begin
            check("t1_b2b", acc_cyc[1] - acc_cyc[0], 1);
            check("t1_wr_lat", ack_cyc[0] - acc_cyc[0], LATENCY);
            check("t1_rd_lat", ack_cyc[1] - acc_cyc[1], LATENCY);
            check("t1_wr_rdata", ack_data[0], 32'h0);
            check("t1_rd_rdata", ack_data[1], 32'hDEADBEEF);
        end
        check("t1_no_err", n_err - base_err, 0);

        // Byte enables.
        req(1'b1, 32'h20, 4'hF, 32'h11223344);
        req(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
        req(1'b0, 32'h20, 4'hF, 32'h0);
        idle(LATENCY + 2);
        check("t2_be_rdata", last_data, 32'h11BB33DD);

        // Out-of-range read and write.
        base_err = n_err;
        base_ack = n_ack;
        req(1'b0, 32'h1000, 4'hF, 32'h0);
        idle(LATENCY + 2);
        check("t3_err_n", n_err - base_err, 1);
        check("t3_ack_n", n_ack - base_ack, 0);
        req(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF);
        req(1'b0, 32'h0, 4'hF, 32'h0);
        idle(LATENCY + 2);
        check("t3_err2_n", n_err - base_err, 2);
        check("t3_word0", last_data, m_mem[0]);

        // Pipelined burst of reads over words 0..7 holding 0..7.
        for (int i = 0; i < 8; i++) req(1'b1, 32'(i * 4), 4'hF, 32'(i));
        idle(LATENCY + 1);
        clear_obs();
        for (int i = 0; i < 8; i++) req(1'b0, 32'(i * 4), 4'hF, 32'h0);
        idle(LATENCY + 2);
        check("t4_ack_n", ack_data.size(), 8);
        if (ack_data.size() == 8 && acc_cyc.size() == 8) begin
            check("t4_first_lat", ack_cyc[0] - acc_cyc[0], LATENCY);
            for (int i = 0; i < 8; i++) check("t4_data", ack_data[i], 32'(i));
        end

        // Stall injection over 10 held requests from a fresh counter.
        do_reset();
        clear_obs();
        base_stall = n_stall_seen;
        for (int i = 0; i < 10; i++) req(1'b0, 32'(i * 4), 4'hF, 32'h0);
        idle(LATENCY + 2);
        check("t5_acc_n", acc_cyc.size(), 10);
        check("t5_ack_n", ack_cyc.size(), 10);
        check("t5_stall_n", n_stall_seen - base_stall, 2);
        if (acc_cyc.size() == 10) begin
            check("t5_span", acc_cyc[9] - acc_cyc[0] + 1, 12);
            check("t5_gap4", acc_cyc[4] - acc_cyc[3], 2);
            check("t5_gap8", acc_cyc[8] - acc_cyc[7], 2);
        end

        // Abort: drop cyc right after two reads.
        base_ack = n_ack;
        req(1'b0, 32'h4, 4'hF, 32'h0);
        req(1'b0, 32'h8, 4'hF, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        idle(LATENCY + 2);
        check("t6_abort_ack", n_ack - base_ack, 0);

        // Abort exactly in the cycle the first response is due.
        base_ack = n_ack;
        req(1'b0, 32'hC, 4'hF, 32'h0);
        req(1'b0, 32'h10, 4'hF, 32'h0);
        idle(LATENCY - 2);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h14, 4'hF, 32'h0);
        idle(LATENCY + 2);
        check("t6_abort_due_ack", n_ack - base_ack, 0);

        // Reset one cycle after an accept.
        base_ack = n_ack;
        req(1'b0, 32'h18, 4'hF, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check("t6_rst_outs", {29'b0, wb_ack_o, wb_err_o, wb_stall_o}, 32'h0);
        check("t6_rst_rdata", wb_rdata_o, 32'h0);
        idle(LATENCY + 2);
        check("t6_rst_ack", n_ack - base_ack, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 99) == 0);
            c = ($urandom_range(0, 15) != 0);
            s = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 15) == 0) a = $urandom | 32'h0000_1000;
            else a = 32'($urandom_range(0, 255));
            step(r, c, s, w, a, 4'($urandom_range(0, 15)), $urandom);
        end
        idle(LATENCY + 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
